// File: rtl/rr_arb7.sv
// rtl/rr_arb7.sv - seven-way round-robin arbiter with hold timeout
// One grant at a time, one idle bubble between grants, grant revoked after TIMEOUT cycles without done.
module rr_arb7 #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] req,
   input  logic       done,
   output logic [6:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;
   localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

   logic [0:0] state_q, state_d;
   logic [6:0] gnt_q, gnt_d;
   logic [2:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       terr_q, terr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] last_q, last_d;

   logic [2:0] win;
   logic       found;
   logic [3:0] cand;

   // Rotating search starting just above the last grantee, wrapping modulo 7.
   always_comb begin
      win   = 3'd0;
      found = 1'b0;
      cand  = 4'd0;
      for (int k = 1; k <= 7; k++) begin
         cand = {1'b0, last_q} + 4'(k);
         if (cand >= 4'd7) cand = cand - 4'd7;
         if (!found && req[cand[2:0]]) begin
            win   = cand[2:0];
            found = 1'b1;
         end
      end
   end

   logic hold_end, withdrew, release_now, timed_out;

   assign hold_end    = (cnt_q == HOLD_MAX);
   assign withdrew    = !req[sel_q];
   assign release_now = done || withdrew || hold_end;
   // A withdrawal or done on the final hold cycle counts as a normal completion.
   assign timed_out   = hold_end && !done && !withdrew;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      terr_d  = 1'b0;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_GRANT;
               gnt_d   = 7'(1) << win;
               sel_d   = win;
               busy_d  = 1'b1;
               cnt_d   = 8'd0;
               last_d  = win;
            end
         end
         default: begin
            if (release_now) begin
               state_d = S_IDLE;
               gnt_d   = 7'd0;
               sel_d   = 3'd0;
               busy_d  = 1'b0;
               cnt_d   = 8'd0;
               terr_d  = timed_out;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 7'd0;
         sel_q   <= 3'd0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
         cnt_q   <= 8'd0;
         last_q  <= 3'd6;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign gnt         = gnt_q;
   assign sel         = sel_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;

endmodule
